ofdm_symbol_writer: RTL and testbench

OFDM_SYMBOL_WRITER -- requirements
Module: ofdm_symbol_writer

---
 rtl/ofdm_symbol_writer.sv | 143 ++++++++++++++
 tb/tb_ofdm_symbol_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_symbol_writer.sv
`timescale 1ns/1ps
// ofdm_symbol_writer
// Fills a 1024-word frequency-domain FFT RAM with one OFDM symbol so that an
// IFFT of the RAM gives a real-valued time-domain signal. Every word is first
// cleared; then 48 QPSK carriers are written at FIRST_BIN + i*BIN_STEP, each
// followed by its complex conjugate at the mirror bin 1024-k.
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous, active-high reset
//   start   one-cycle request, accepted only when idle
//   data    96-bit payload, bit pair i = {data[2i+1] (imag), data[2i] (real)}
//   busy    high from the cycle after an accepted start through finish
//   finish  one-cycle pulse when the symbol is complete
//   oce     RAM output clock enable (write-only block, always 0)
//   ce      RAM clock enable
//   wre     RAM write enable
//   ad      RAM word address
//   din     RAM write word, {real[15:0], imag[15:0]} signed
module ofdm_symbol_writer #(
    parameter int FIRST_BIN = 16,
    parameter int BIN_STEP  = 4,
    parameter int AMP       = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [95:0] data,
    output logic        busy,
    output logic        finish,
    output logic        oce,
    output logic        ce,
    output logic        wre,
    output logic [10:0] ad,
    output logic [31:0] din
);

    typedef enum logic [1:0] {IDLE, CLEAR, MAP, DONE} state_t;

    localparam logic [10:0]        FIRST_AD = 11'(FIRST_BIN);
    localparam logic [10:0]        STEP_AD  = 11'(BIN_STEP);
    localparam logic [10:0]        N_AD     = 11'd1024;
    localparam logic signed [15:0] AMP_S    = 16'(AMP);

    state_t      state;
    logic [95:0] data_q;     // latched payload, shifted down one pair per carrier
    logic [5:0]  pair_idx;   // carrier currently on the RAM port
    logic        mirror;     // 1 while the conjugate (mirror-bin) word is on the port
    logic [10:0] bin_k;      // data bin of the current carrier

    // QPSK component: bit 0 -> +AMP, bit 1 -> -AMP
    function automatic logic signed [15:0] qpsk(input logic b);
        return b ? -AMP_S : AMP_S;
    endfunction

    function automatic logic [31:0] pack(input logic signed [15:0] re,
                                         input logic signed [15:0] im);
        return {re, im};
    endfunction

    // Conjugate keeps the real half and negates the imaginary half
    function automatic logic [31:0] conj(input logic [31:0] w);
        logic signed [15:0] im;
        im = w[15:0];
        return {w[31:16], -im};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_q   <= '0;
            pair_idx <= '0;
            mirror   <= 1'b0;
            bin_k    <= '0;
            busy     <= 1'b0;
            finish   <= 1'b0;
            oce      <= 1'b0;
            ce       <= 1'b0;
            wre      <= 1'b0;
            ad       <= '0;
            din      <= '0;
        end else begin
            oce <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // First clear write goes out in the very next cycle
                        state  <= CLEAR;
                        data_q <= data;
                        busy   <= 1'b1;
                        ce     <= 1'b1;
                        wre    <= 1'b1;
                        ad     <= '0;
                        din    <= '0;
                    end
                end
                CLEAR: begin
                    if (ad == 11'd1023) begin
                        state    <= MAP;
                        ad       <= FIRST_AD;
                        bin_k    <= FIRST_AD;
                        pair_idx <= '0;
                        mirror   <= 1'b0;
                        din      <= pack(qpsk(data_q[0]), qpsk(data_q[1]));
                    end else begin
                        ad <= ad + 11'd1;
                    end
                end
                MAP: begin
                    if (!mirror) begin
                        mirror <= 1'b1;
                        ad     <= N_AD - bin_k;
                        din    <= conj(din);
                    end else if (pair_idx == 6'd47) begin
                        state  <= DONE;
                        ce     <= 1'b0;
                        wre    <= 1'b0;
                        ad     <= '0;
                        din    <= '0;
                        finish <= 1'b1;
                    end else begin
                        // Next pair sits in bits [3:2] before the shift lands it at [1:0]
                        mirror   <= 1'b0;
                        pair_idx <= pair_idx + 6'd1;
                        bin_k    <= bin_k + STEP_AD;
                        ad       <= bin_k + STEP_AD;
                        din      <= pack(qpsk(data_q[2]), qpsk(data_q[3]));
                        data_q   <= data_q >> 2;
                    end
                end
                DONE: begin
                    finish <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ofdm_symbol_writer.sv
`timescale 1ns/1ps
module tb_ofdm_symbol_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [95:0] data;
    logic        busy;
    logic        finish;
    logic        oce;
    logic        ce;
    logic        wre;
    logic [10:0] ad;
    logic [31:0] din;

    ofdm_symbol_writer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data   (data),
        .busy   (busy),
        .finish (finish),
        .oce    (oce),
        .ce     (ce),
        .wre    (wre),
        .ad     (ad),
        .din    (din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int edge_no = 0;
    always @(posedge clk) edge_no <= edge_no + 1;

    // Monitor / RAM model, sampled on the falling edge
    int          S = 0;
    logic        mon_on = 1'b0;
    logic        mon_clr = 1'b0;
    logic [31:0] ram [1024];
    int          wcyc [1024];
    int          busy_cnt, fin_cnt, fin_cyc, map_writes, oce_bad, bad_ad;

    always @(negedge clk) begin
        if (mon_clr) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i]  <= 32'hFFFF_FFFF;
                wcyc[i] <= -1;
            end
            busy_cnt   <= 0;
            fin_cnt    <= 0;
            fin_cyc    <= 0;
            map_writes <= 0;
            oce_bad    <= 0;
            bad_ad     <= 0;
        end else if (mon_on) begin
            if (oce) oce_bad <= oce_bad + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (finish) begin
                fin_cnt <= fin_cnt + 1;
                fin_cyc <= edge_no - S + 1;
            end
            if (ce && wre) begin
                if (ad > 11'd1023) bad_ad <= bad_ad + 1;
                else begin
                    ram[ad[9:0]]  <= din;
                    wcyc[ad[9:0]] <= edge_no - S + 1;
                end
                if (edge_no - S + 1 >= 1025) map_writes <= map_writes + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected word, independent of the RTL: AMP=8192 -> +0x2000 / -0xE000
    function automatic logic [31:0] exp_word(input logic [95:0] d, input int a);
        logic [31:0] w;
        int k;
        w = '0;
        for (int i = 0; i < 48; i++) begin
            k = 16 + 4 * i;
            if (a == k)
                w = {d[2*i] ? 16'hE000 : 16'h2000, d[2*i+1] ? 16'hE000 : 16'h2000};
            else if (a == 1024 - k)
                w = {d[2*i] ? 16'hE000 : 16'h2000, d[2*i+1] ? 16'h2000 : 16'hE000};
        end
        return w;
    endfunction

    function automatic int exp_cyc(input int a);
        int c;
        int k;
        c = a + 1;
        for (int i = 0; i < 48; i++) begin
            k = 16 + 4 * i;
            if (a == k) c = 1025 + 2 * i;
            else if (a == 1024 - k) c = 1026 + 2 * i;
        end
        return c;
    endfunction

    task automatic start_run(input logic [95:0] d);
        @(posedge clk); #1;
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
        @(posedge clk); #1;
        data  = d;
        start = 1'b1;
        @(posedge clk); #1;       // start sampled at this edge (edge 0)
        S      = edge_no;
        start  = 1'b0;
        data   = ~d;              // must not affect the symbol in flight
        mon_on = 1'b1;
    endtask

    task automatic run_to_end(input int s1, input int s2);
        int c;
        int guard;
        guard = 0;
        while (guard < 1400) begin
            @(posedge clk); #1;
            c = edge_no - S + 1;
            start = (c == s1) || (c == s2);
            guard++;
            if (fin_cnt > 0 && c > fin_cyc + 10) break;
        end
        start  = 1'b0;
        mon_on = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [95:0] d);
        int bad_w, bad_c;
        int nzk[$];
        real im, mx, ang, rk, ik;
        logic signed [15:0] h;
        bad_w = 0;
        bad_c = 0;
        chk({tag, " fin_cnt"},    64'(fin_cnt), 64'd1);
        chk({tag, " fin_cyc"},    64'(fin_cyc), 64'd1121);
        chk({tag, " busy_cyc"},   64'(busy_cnt), 64'd1121);
        chk({tag, " map_writes"}, 64'(map_writes), 64'd96);
        chk({tag, " oce_zero"},   64'(oce_bad), 64'd0);
        chk({tag, " ad_range"},   64'(bad_ad), 64'd0);
        for (int a = 0; a < 1024; a++) begin
            if (ram[a] !== exp_word(d, a)) begin
                if (bad_w == 0)
                    $display("FAIL %s ram[%0d]: got %h expected %h", tag, a, ram[a], exp_word(d, a));
                bad_w++;
            end
            if (wcyc[a] != exp_cyc(a)) bad_c++;
            if (ram[a] != 32'h0) nzk.push_back(a);
        end
        chk({tag, " ram_words_bad"}, 64'(bad_w), 64'd0);
        chk({tag, " write_cycles_bad"}, 64'(bad_c), 64'd0);
        // Imaginary part of the (1/N-scaled) IFFT at every time sample
        mx = 0.0;
        for (int n = 0; n < 1024; n++) begin
            im = 0.0;
            foreach (nzk[j]) begin
                h  = ram[nzk[j]][31:16];
                rk = h;
                h  = ram[nzk[j]][15:0];
                ik = h;
                ang = 2.0 * 3.14159265358979 * real'(nzk[j]) * real'(n) / 1024.0;
                im = im + rk * $sin(ang) + ik * $cos(ang);
            end
            im = im / 1024.0;
            if (im < 0.0) im = -im;
            if (im > mx) mx = im;
        end
        chk({tag, " ifft_imag_le_1lsb"}, 64'(mx <= 1.0), 64'd1);
    endtask

    typedef struct {
        int          run;
        int          addr;
        logic [31:0] word;
        int          cyc;
    } vec_t;

    vec_t        vecs [16];
    logic [95:0] run_data [3];

    initial begin
        vecs[0]  = '{0, 16,   32'h2000_2000, 1025};
        vecs[1]  = '{0, 1008, 32'h2000_E000, 1026};
        vecs[2]  = '{0, 0,    32'h0000_0000, 1};
        vecs[3]  = '{0, 1,    32'h0000_0000, 2};
        vecs[4]  = '{0, 17,   32'h0000_0000, 18};
        vecs[5]  = '{0, 512,  32'h0000_0000, 513};
        vecs[6]  = '{1, 16,   32'hE000_E000, 1025};
        vecs[7]  = '{1, 1008, 32'hE000_2000, 1026};
        vecs[8]  = '{1, 204,  32'hE000_E000, 1119};
        vecs[9]  = '{1, 820,  32'hE000_2000, 1120};
        vecs[10] = '{2, 16,   32'hE000_2000, 1025};
        vecs[11] = '{2, 1008, 32'hE000_E000, 1026};
        vecs[12] = '{2, 20,   32'h2000_2000, 1027};
        vecs[13] = '{2, 1004, 32'h2000_E000, 1028};
        vecs[14] = '{2, 204,  32'h2000_2000, 1119};
        vecs[15] = '{2, 820,  32'h2000_E000, 1120};
        run_data[0] = '0;
        run_data[1] = '1;
        run_data[2] = 96'h1;

        rst   = 1'b0;
        start = 1'b0;
        data  = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset outputs", {52'd0, busy, finish, oce, ce, wre, ad != 11'd0, din != 32'd0},
            64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int r = 0; r < 3; r++) begin
            start_run(run_data[r]);
            // Run 0 also tries a start during CLEAR and one coincident with finish
            if (r == 0) run_to_end(500, 1121);
            else run_to_end(0, 0);
            check_run($sformatf("run%0d", r), run_data[r]);
            for (int v = 0; v < 16; v++) begin
                if (vecs[v].run == r) begin
                    chk($sformatf("run%0d bin%0d word", r, vecs[v].addr),
                        64'(ram[vecs[v].addr]), 64'(vecs[v].word));
                    chk($sformatf("run%0d bin%0d cycle", r, vecs[v].addr),
                        64'(wcyc[vecs[v].addr]), 64'(vecs[v].cyc));
                end
            end
        end

        // Abort in MAP at cycle 1050, then a fresh run
        start_run(96'h5A5A_0F0F_3C3C_9696_C3C3_A5A5);
        while (edge_no - S + 1 < 1050) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("abort outputs", {52'd0, busy, finish, oce, ce, wre, ad != 11'd0, din != 32'd0},
            64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort no finish", 64'(fin_cnt), 64'd0);
        chk("abort idle busy", {63'd0, busy}, 64'd0);
        mon_on = 1'b0;
        start_run(96'h0123_4567_89AB_CDEF_FEDC_BA98);
        run_to_end(0, 0);
        check_run("after_abort", 96'h0123_4567_89AB_CDEF_FEDC_BA98);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
